// File: rtl/arb_mux_nto1.sv
// -----------------------------------------------------------------------------
// arb_mux_nto1 -- N-to-1 arbitrated mux with a registered output stage.
//
// Each cycle one requesting channel is picked, either round-robin (RR=1) or by
// fixed priority with the lowest index first (RR=0). The picked channel's
// payload is captured into a single output register. That register refills in
// the same cycle it drains, so the mux can sustain one transfer per cycle.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   [N]        per-channel request
//   in_data    [N][W]     per-channel payload (unpacked array)
//   in_ready   [N]        per-channel accept; one-hot or zero, combinational
//   out_valid             out_data/out_sel hold a transfer
//   out_data   [W]        registered payload of the granted channel
//   out_sel    [SW]       index of the channel that produced out_data
//   out_ready             downstream accepts the current output
// -----------------------------------------------------------------------------

// Per-channel slice. It qualifies the request against the round-robin pointer
// and turns the grant into this channel's ready.
module arb_mux_lane #(
    parameter int IDX = 0,
    parameter int SW  = 2,
    parameter bit RR  = 1'b1
) (
    input  logic          req,
    input  logic [SW-1:0] ptr,
    input  logic          gnt,
    input  logic          load_en,
    output logic          req_hi,
    output logic          ready
);
    // req_hi marks requests at or above the pointer. These channels win before
    // any request that sits below the pointer (the wrap-around part of the
    // search). Fixed priority never uses this upper region.
    assign req_hi = RR ? (req && (int'(ptr) <= IDX)) : 1'b0;
    assign ready  = gnt & load_en;
endmodule

module arb_mux_nto1 #(
    parameter int N  = 4,
    parameter int W  = 16,
    parameter bit RR = 1'b1,
    parameter int SW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [W-1:0]         in_data [N],
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [SW-1:0]        out_sel,
    input  logic                 out_ready
);
    localparam int STAGES = 1;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [SW-1:0] sel;
    } out_t;

    // vld_pipe[0]: a channel transfer happens this cycle.
    // vld_pipe[1]: the output register holds a transfer (out_valid).
    logic [STAGES:0] vld_pipe;
    out_t            out_q;
    logic [SW-1:0]   ptr;

    logic            load_en;
    logic            any_req;
    logic [N-1:0]    req_hi;
    logic            hi_any;
    logic [SW-1:0]   hi_idx;
    logic [SW-1:0]   lo_idx;
    logic [SW-1:0]   g;
    logic [N-1:0]    gnt_oh;

    assign load_en     = !vld_pipe[STAGES] || out_ready;
    assign any_req     = |in_valid;
    assign vld_pipe[0] = any_req && load_en && !rst;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_lane
            arb_mux_lane #(.IDX(i), .SW(SW), .RR(RR)) u_lane (
                .req     (in_valid[i]),
                .ptr     (ptr),
                .gnt     (gnt_oh[i]),
                .load_en (load_en),
                .req_hi  (req_hi[i]),
                .ready   (in_ready[i])
            );
        end
    endgenerate

    // Two lowest-index-first encoders. When any request sits at or above the
    // pointer, the lowest such request wins. Otherwise the search has wrapped
    // and the lowest request overall wins. With RR=0, req_hi is always zero,
    // which reduces this to plain fixed priority.
    always_comb begin
        hi_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_hi[k]) begin
                hi_any = 1'b1;
                hi_idx = SW'(k);
            end
            if (in_valid[k]) begin
                lo_idx = SW'(k);
            end
        end
    end

    assign g = hi_any ? hi_idx : lo_idx;

    // The grant is gated by reset so that in_ready stays low while rst is high.
    always_comb begin
        gnt_oh = '0;
        if (any_req && !rst) begin
            gnt_oh = N'(1) << g;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[STAGES:1] <= '0;
            out_q              <= '0;
            ptr                <= '0;
        end else if (load_en) begin
            // When the mux drains with no new request, out_valid drops.
            // The data and select fields keep their last values.
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (vld_pipe[0]) begin
                out_q.data <= in_data[g];
                out_q.sel  <= g;
                ptr        <= (g == SW'(N - 1)) ? '0 : g + SW'(1);
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_data  = out_q.data;
    assign out_sel   = out_q.sel;
endmodule

// File: tb/tb_arb_mux_nto1.sv
// -----------------------------------------------------------------------------
// tb_arb_mux_nto1 -- directed bench for arb_mux_nto1.
// One round-robin instance (dut_rr) and one fixed-priority instance (dut_fp)
// share the clock, reset and payloads. Each has its own valid and ready.
// -----------------------------------------------------------------------------
module tb_arb_mux_nto1;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_data [N];

    logic [N-1:0]  valid_a, ready_a;
    logic          ovalid_a, oready_a;
    logic [W-1:0]  odata_a;
    logic [SW-1:0] osel_a;

    logic [N-1:0]  valid_b, ready_b;
    logic          ovalid_b, oready_b;
    logic [W-1:0]  odata_b;
    logic [SW-1:0] osel_b;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    arb_mux_nto1 #(.N(N), .W(W), .RR(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .in_valid(valid_a), .in_data(in_data),
        .in_ready(ready_a), .out_valid(ovalid_a), .out_data(odata_a),
        .out_sel(osel_a), .out_ready(oready_a)
    );

    arb_mux_nto1 #(.N(N), .W(W), .RR(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .in_valid(valid_b), .in_data(in_data),
        .in_ready(ready_b), .out_valid(ovalid_b), .out_data(odata_b),
        .out_sel(osel_b), .out_ready(oready_b)
    );

    // Every cycle: in_ready must be zero or one-hot, and at most one channel
    // may transfer.
    always @(negedge clk) begin
        vectors++;
        if (!$onehot0(ready_a) || !$onehot0(ready_b)) begin
            miscompares++;
            $display("FAIL onehot_ready: got rr=%b fp=%b, want zero or one-hot", ready_a, ready_b);
        end
        vectors++;
        if ($countones(valid_a & ready_a) > 1 || $countones(valid_b & ready_b) > 1) begin
            miscompares++;
            $display("FAIL single_xfer: got rr=%b fp=%b, want at most one transfer",
                     valid_a & ready_a, valid_b & ready_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_a = 4'b1111; oready_a = 1'b1;
        valid_b = 4'b0000; oready_b = 1'b1;
        step();
        vectors++;
        if ({ovalid_a, odata_a, osel_a, ready_a} !== {1'b0, 16'h0000, 2'd0, 4'b0000}) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b d=%h s=%0d r=%b, want 0/0000/0/0000",
                     ovalid_a, odata_a, osel_a, ready_a);
        end
        rst = 1'b0;
    endtask

    task automatic test_rr_rotate();
        valid_a = 4'b1111; oready_a = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (ready_a !== 4'(1 << (k % 4))) begin
                miscompares++;
                $display("FAIL rr_ready[%0d]: got %b want %b", k, ready_a, 4'(1 << (k % 4)));
            end
            step();
            vectors++;
            if ({ovalid_a, osel_a, odata_a} !== {1'b1, 2'(k % 4), 16'(16'hA000 + k % 4)}) begin
                miscompares++;
                $display("FAIL rr_out[%0d]: got v=%b s=%0d d=%h want 1/%0d/%h",
                         k, ovalid_a, osel_a, odata_a, k % 4, 16'hA000 + k % 4);
            end
        end
    endtask

    task automatic test_stall();
        // The pointer is 0 here. Granting channel 2 loads A002 and moves the pointer to 3.
        valid_a = 4'b0100;
        step();
        oready_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid_a = (k == 1) ? 4'b0011 : 4'b1111;
            #1;
            vectors++;
            if (ready_a !== 4'b0000) begin
                miscompares++;
                $display("FAIL stall_ready[%0d]: got %b want 0000", k, ready_a);
            end
            step();
            vectors++;
            if ({ovalid_a, osel_a, odata_a} !== {1'b1, 2'd2, 16'hA002}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got v=%b s=%0d d=%h want 1/2/a002",
                         k, ovalid_a, osel_a, odata_a);
            end
        end
        valid_a = 4'b1111; oready_a = 1'b1;
        #1;
        vectors++;
        if (ready_a !== 4'b1000) begin
            miscompares++;
            $display("FAIL stall_release_ready: got %b want 1000", ready_a);
        end
        step();
        vectors++;
        if ({osel_a, odata_a} !== {2'd3, 16'hA003}) begin
            miscompares++;
            $display("FAIL stall_release_out: got s=%0d d=%h want 3/a003", osel_a, odata_a);
        end
    endtask

    task automatic test_wrap_drain();
        // The pointer is 0 here. Granting channel 2 moves it to 3.
        valid_a = 4'b0100;
        step();
        valid_a = 4'b0001;
        #1;
        vectors++;
        if (ready_a !== 4'b0001) begin
            miscompares++;
            $display("FAIL wrap_ready: got %b want 0001", ready_a);
        end
        step();
        vectors++;
        if ({ovalid_a, osel_a, odata_a} !== {1'b1, 2'd0, 16'hA000}) begin
            miscompares++;
            $display("FAIL wrap_out: got v=%b s=%0d d=%h want 1/0/a000", ovalid_a, osel_a, odata_a);
        end
        valid_a = 4'b0000;
        step();
        vectors++;
        if ({ovalid_a, osel_a, odata_a} !== {1'b0, 2'd0, 16'hA000}) begin
            miscompares++;
            $display("FAIL drain_out: got v=%b s=%0d d=%h want 0/0/a000", ovalid_a, osel_a, odata_a);
        end
        // The wrap grant left the pointer at 1.
        valid_a = 4'b1111;
        #1;
        vectors++;
        if (ready_a !== 4'b0010) begin
            miscompares++;
            $display("FAIL ptr_after_wrap: got %b want 0010", ready_a);
        end
        step();
        vectors++;
        if ({ovalid_a, osel_a, odata_a} !== {1'b1, 2'd1, 16'hA001}) begin
            miscompares++;
            $display("FAIL refill_out: got v=%b s=%0d d=%h want 1/1/a001", ovalid_a, osel_a, odata_a);
        end
    endtask

    task automatic test_fixed();
        valid_b = 4'b1010; oready_b = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (ready_b !== 4'b0010) begin
                miscompares++;
                $display("FAIL fp_ready[%0d]: got %b want 0010", k, ready_b);
            end
            step();
            vectors++;
            if ({ovalid_b, osel_b, odata_b} !== {1'b1, 2'd1, 16'hA001}) begin
                miscompares++;
                $display("FAIL fp_out[%0d]: got v=%b s=%0d d=%h want 1/1/a001",
                         k, ovalid_b, osel_b, odata_b);
            end
        end
        valid_b = 4'b0000;
    endtask

    task automatic test_async_reset();
        // out_valid is 1 with sel=1 and data A001. Hold the output, then reset mid-cycle.
        valid_a = 4'b1111; oready_a = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({ovalid_a, odata_a, osel_a, ready_a} !== {1'b0, 16'h0000, 2'd0, 4'b0000}) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b d=%h s=%0d r=%b want 0/0000/0/0000",
                     ovalid_a, odata_a, osel_a, ready_a);
        end
        step();
        rst = 1'b0; valid_a = 4'b1100; oready_a = 1'b1;
        #1;
        vectors++;
        if (ready_a !== 4'b0100) begin
            miscompares++;
            $display("FAIL post_reset_ready: got %b want 0100", ready_a);
        end
        step();
        vectors++;
        if ({ovalid_a, osel_a, odata_a} !== {1'b1, 2'd2, 16'hA002}) begin
            miscompares++;
            $display("FAIL post_reset_out: got v=%b s=%0d d=%h want 1/2/a002",
                     ovalid_a, osel_a, odata_a);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) in_data[k] = 16'hA000 + 16'(k);
        test_reset();
        test_rr_rotate();
        test_stall();
        test_wrap_drain();
        test_fixed();
        test_async_reset();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/arb_mux_nto1.md
ARB_MUX_NTO1 -- requirements
Module: arb_mux_nto1

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of input channels (N >= 2).
REQ-002 SHALL have parameter W, default 16, meaning data width of every channel.
REQ-003 SHALL have parameter RR, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority with lowest index first.
REQ-004 SHALL define SW = $clog2(N) as the select/grant index width.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  N  per-channel request; bit i set means in_data[i] is offered.
REQ-008 in_data  input  unpacked array [N] of W bits  per-channel payload.
REQ-009 in_ready  output  N  per-channel accept; one-hot or zero.
REQ-010 out_valid  output  1  out_data/out_sel hold a transfer.
REQ-011 out_data  output  W  registered payload of the granted channel.
REQ-012 out_sel  output  SW  index of the channel that produced out_data.
REQ-013 out_ready  input  1  downstream accepts the current output.

Function
REQ-014 A channel transfer SHALL occur in a cycle where in_valid[i] and in_ready[i] are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-015 load_en SHALL be (!out_valid || out_ready), so the output register can be refilled in the same cycle it drains (full throughput, one transfer per cycle).
REQ-016 in_ready SHALL be combinational: in_ready[g] = 1 only for the granted index g, only when load_en = 1 and in_valid != 0; otherwise in_ready = 0.
REQ-017 RR = 0: g SHALL be the lowest index i with in_valid[i] = 1.
REQ-018 RR = 1: g SHALL be the first index i with in_valid[i] = 1 searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N).
REQ-019 ptr (SW bits) SHALL update to (g+1) mod N on every channel transfer, wrapping from N-1 to 0; it SHALL hold otherwise.
REQ-020 On a channel transfer, out_data <= in_data[g], out_sel <= g, out_valid <= 1 at the next edge; latency input-to-output is exactly 1 cycle.
REQ-021 If load_en = 1 and in_valid = 0, out_valid SHALL go to 0 next edge; out_data/out_sel hold their last values.
REQ-022 If load_en = 0 (out_valid = 1, out_ready = 0), out_valid, out_data, out_sel and ptr SHALL hold; in_ready = 0 (backpressure to all channels).
REQ-023 Grant SHALL not depend on in_data; in_valid changes while stalled SHALL not alter held output.
REQ-024 A channel deasserting in_valid before grant SHALL lose nothing; no request is latched internally.
REQ-025 Simultaneous drain and refill SHALL keep out_valid = 1 with the new data on the next edge.

Reset
REQ-026 While rst = 1: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0, immediately (asynchronously) and regardless of clk.
REQ-027 in_ready SHALL be 0 while rst = 1.
REQ-028 Reset asserted mid-transfer SHALL discard the held output; first grant after release SHALL search from index 0.

Verification
REQ-029 N=4, W=16, RR=1, out_ready=1, in_valid=4'b1111, data i = 16'hA000+i for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, each one cycle after grant, out_valid continuously 1.
REQ-030 RR=0, in_valid=4'b1010 held, out_ready=1 -> out_sel always 1, in_ready = 4'b0010 every cycle, channel 3 starved.
REQ-031 RR=1, out_valid=1 with out_data=16'hA002, out_ready=0 for 3 cycles, in_valid=4'b1111 -> in_ready=0, out_data/out_sel/ptr unchanged; raise out_ready -> next grant is channel 3.
REQ-032 RR=1, ptr=3, in_valid=4'b0001 -> grant 0 (wrap), ptr becomes 1; then in_valid=0, out_ready=1 -> out_valid drops to 0 next edge, out_data stays 16'hA000.
REQ-033 Assert rst asynchronously between edges while out_valid=1 -> out_valid, out_data, out_sel go to 0 without a clock edge; after release with in_valid=4'b1100 -> grant 2.
REQ-034 Every cycle the bench SHALL check in_ready is zero or one-hot, and that at most one channel transfer occurs per cycle.
